// File: rtl/ram_stream_pkg.sv
// Shared types and width helpers for the RAM word-stream reader.
package ram_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int calc_ratio(input int addr_w1, input int addr_w2);
    return 1 << (addr_w1 - addr_w2);
  endfunction

  function automatic int calc_data_width2(input int data_w1, input int addr_w1, input int addr_w2);
    return data_w1 * calc_ratio(addr_w1, addr_w2);
  endfunction

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word FIFO sitting between the RAM read port and the byte unpacker.
module word_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage is data only; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ram_word_stream_reader.sv
// Reads len_words words from the RAM word port and streams them out as bytes, MS byte first.
// Optional RAM_STREAM_CHECKSUM_EN adds a running modulo-2^DATA_WIDTH1 byte checksum output.
module ram_word_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int DATA_WIDTH1    = 8,
  parameter int ADDRESS_WIDTH1 = 32,
  parameter int ADDRESS_WIDTH2 = 30,
  parameter int LEN_WIDTH      = 16,
  localparam int RATIO         = calc_ratio(ADDRESS_WIDTH1, ADDRESS_WIDTH2),
  localparam int DATA_WIDTH2   = calc_data_width2(DATA_WIDTH1, ADDRESS_WIDTH1, ADDRESS_WIDTH2)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDRESS_WIDTH2-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]      len_words,
  output logic                      busy,
  output logic                      done,
  output logic [ADDRESS_WIDTH2-1:0] ram_addr,
  output logic                      ram_we,
  input  logic [DATA_WIDTH2-1:0]    ram_rdata,
  output logic [DATA_WIDTH1-1:0]    out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last
`ifdef RAM_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH1-1:0]    checksum
`endif
);

  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  state_t                  state;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    issued;
  logic [LEN_WIDTH-1:0]    popped;
  logic [1:0]              credits;
  logic                    rd_pending_p1;
  logic [LANE_W-1:0]       lane;
  logic [DATA_WIDTH2-1:0]  head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    accept;
  logic                    issue;
  logic                    last_issue;
  logic                    handshake;
  logic                    lane_end;
  logic                    pop;
  logic                    last_word;

  assign accept     = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign issue      = (state == ST_FETCH) && (issued != len_q) && (credits < 2'd2);
  assign last_issue = (issued + LEN_WIDTH'(1)) == len_q;
  assign out_valid  = !fifo_empty;
  assign handshake  = out_valid && out_ready;
  assign lane_end   = (lane == LANE_W'(RATIO - 1));
  assign pop        = handshake && lane_end;
  assign last_word  = (popped == (len_q - LEN_WIDTH'(1)));
  assign out_last   = out_valid && last_word && lane_end;
  assign out_data   = out_valid ? head[(RATIO - 1 - int'(lane)) * DATA_WIDTH1 +: DATA_WIDTH1]
                                : '0;
  assign busy       = (state == ST_FETCH) || (state == ST_DRAIN);
  assign done       = (state == ST_DONE);
  assign ram_we     = 1'b0;

  word_fifo2 #(
    .WIDTH (DATA_WIDTH2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .push  (rd_pending_p1),
    .wdata (ram_rdata),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stage p0 -> p1: read issued this cycle lands in the FIFO next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ram_addr      <= '0;
      len_q         <= '0;
      issued        <= '0;
      rd_pending_p1 <= 1'b0;
    end else begin
      rd_pending_p1 <= issue;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            ram_addr <= base_addr;
            len_q    <= len_words;
            issued   <= '0;
            state    <= (len_words == '0) ? ST_DONE : ST_FETCH;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (issue) begin
            issued <= issued + LEN_WIDTH'(1);
            // Pointer stays on the final address so ram_addr never runs past the transfer.
            if (last_issue) state <= ST_DRAIN;
            else            ram_addr <= ram_addr + ADDRESS_WIDTH2'(1);
          end
        end
        ST_DRAIN: begin
          if (pop && last_word) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= 2'd0;
      lane    <= '0;
      popped  <= '0;
    end else if (accept) begin
      credits <= 2'd0;
      lane    <= '0;
      popped  <= '0;
    end else begin
      credits <= credits + {1'b0, issue} - {1'b0, pop};
      if (handshake) lane <= lane_end ? '0 : lane + LANE_W'(1);
      if (pop) popped <= popped + LEN_WIDTH'(1);
    end
  end

`ifdef RAM_STREAM_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         checksum <= '0;
    else if (accept)    checksum <= '0;
    else if (handshake) checksum <= checksum + out_data;
  end
`endif

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_ram_word_stream_reader.sv
// Randomized self-checking bench for ram_word_stream_reader against a byte-queue reference model.
module tb_ram_word_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [29:0] base_addr = '0;
  logic [15:0] len_words = '0;
  logic        busy;
  logic        done;
  logic [29:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_rdata = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
`ifdef RAM_STREAM_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] ram [logic [29:0]];

  ram_word_stream_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len_words (len_words),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef RAM_STREAM_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [29:0] a);
    if (ram.exists(a)) return ram[a];
    return {2'b10, a};
  endfunction

  // Word-port RAM model: one-cycle registered read.
  always @(posedge clk) ram_rdata <= ram_word(ram_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_xfer(input logic [29:0] base, input int len, input int mode,
                          input int abort_after, input bit poke_start, output bit aborted);
    logic [7:0]  exp_q[$];
    logic [29:0] exp_addr[$];
    logic [29:0] seq[$];
    logic [31:0] w;
    logic [29:0] a;
    logic [7:0]  e;
    logic [7:0]  sum = '0;
    logic [7:0]  pd = '0;
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    bit          we_seen = 0, hold_bad = 0, v_seen = 0;
    int          got = 0, first_v = -1, done_cyc = -1;
    aborted = 0;
    for (int i = 0; i < len; i++) begin
      a = base + 30'(i);
      exp_addr.push_back(a);
      w = ram_word(a);
      for (int k = 0; k < 4; k++) exp_q.push_back(w[31 - 8*k -: 8]);
    end
    @(negedge clk);
    start = 1'b1; base_addr = base; len_words = 16'(len);
    @(posedge clk); #1;
    start = 1'b0; base_addr = 30'($urandom); len_words = 16'($urandom);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      start = poke_start && (cyc == 4);
      @(negedge clk);
      if (cyc == 1 && len > 0) begin
        chk("busy_cycle1", busy, 1);
        chk("addr_cycle1", ram_addr, base);
      end
      if (ram_we) we_seen = 1;
      if (busy && (seq.size() == 0 || seq[$] != ram_addr)) seq.push_back(ram_addr);
      if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) hold_bad = 1;
      if (out_valid) begin
        v_seen = 1;
        if (first_v < 0) first_v = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("byte%0d", got), out_data, e);
          chk($sformatf("last%0d", got), out_last, exp_q.size() == 0);
          sum += e;
          got++;
        end
        if (abort_after != 0 && got == abort_after) begin
          aborted = 1;
          break;
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (aborted) return;
    chk("done_seen", done_cyc > 0, 1);
    chk("bytes_left", exp_q.size(), 0);
    chk("we_never", we_seen, 0);
    chk("stall_hold", hold_bad, 0);
    chk("addr_seq_len", seq.size(), len);
    for (int i = 0; i < seq.size() && i < len; i++)
      chk($sformatf("addr_seq%0d", i), seq[i], exp_addr[i]);
    if (len == 0) begin
      chk("len0_no_valid", v_seen, 0);
      chk("len0_done_cycle", done_cyc, 1);
    end else if (mode == 0) begin
      chk("first_valid_cycle", first_v, 3);
      chk("done_cycle", done_cyc, 3 + 4*len);
    end
`ifdef RAM_STREAM_CHECKSUM_EN
    if (done_cyc > 0) chk("checksum", checksum, sum);
`endif
  endtask

  initial begin
    bit ab;
    int n;
    logic [29:0] b;
    ram[30'h0] = 32'h1122_3344;
    ram[30'h1] = 32'hAABB_CCDD;
    ram[30'h2] = 32'h5566_7788;
    ram[30'h3] = 32'h99EE_FF01;
    ram[30'h3FFF_FFFF] = $urandom;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", out_data, 0);
    rst_n = 1'b1;

    run_xfer(30'h0, 2, 0, 0, 0, ab);
    run_xfer(30'h0, 2, 1, 0, 0, ab);
    run_xfer(30'h0, 0, 0, 0, 0, ab);
    run_xfer(30'h3FFF_FFFF, 2, 0, 0, 0, ab);
    run_xfer(30'h0, 3, 0, 0, 1, ab);

    run_xfer(30'h0, 4, 0, 3, 0, ab);
    chk("abort_reached", ab, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_last", out_last, 0);
    chk("abort_we", ram_we, 0);
    chk("abort_addr", ram_addr, 0);
    chk("abort_data", out_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_xfer(30'h1, 1, 0, 0, 0, ab);

    for (int t = 0; t < 10; t++) begin
      b = 30'($urandom);
      n = (t == 7) ? 0 : $urandom_range(1, 6);
      for (int i = 0; i < n; i++) ram[b + 30'(i)] = $urandom;
      run_xfer(b, n, $urandom_range(0, 2), 0, 0, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
